// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module   : music_pkg
// Purpose  : Song identifiers, song lengths and the song priority helper.
// Revision : 1.0
// ============================================================================
package music_pkg;

    typedef enum logic [1:0] {
        SONG_NONE  = 2'd0,
        SONG_THEME = 2'd1,
        SONG_EAT   = 2'd2,
        SONG_DEATH = 2'd3
    } song_e;

    localparam int THEME_LEN = 48;
    localparam int EAT_LEN   = 8;
    localparam int DEATH_LEN = 16;

    function automatic logic [1:0] prio(input song_e s);
        case (s)
            SONG_THEME: prio = 2'd1;
            SONG_EAT:   prio = 2'd2;
            SONG_DEATH: prio = 2'd3;
            default:    prio = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_index_counter.sv
`default_nettype none
// ============================================================================
// Module   : note_index_counter
// Purpose  : Tempo prescaler plus note index that wraps after last_idx.
// Revision : 1.0
// ============================================================================
module note_index_counter
    import music_pkg::*;
#(
    parameter int TICKS_PER_NOTE = 6_250_000,
    parameter int TICK_W         = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load0,
    input  logic [5:0] last_idx,
    output logic [5:0] note_idx,
    output logic       note_tick,
    output logic       at_end
);

    localparam logic [TICK_W-1:0] c_PRESC_LAST = TICK_W'(TICKS_PER_NOTE - 1);

    logic [TICK_W-1:0] r_presc;
    logic [5:0]        r_idx;
    logic              w_note_last_cycle;

    assign w_note_last_cycle = (r_presc == c_PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (en) begin
            if (load0) begin
                r_presc <= '0;
                r_idx   <= '0;
            end else if (w_note_last_cycle) begin
                r_presc <= '0;
                r_idx   <= (r_idx == last_idx) ? 6'd0 : r_idx + 6'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign note_idx  = r_idx;
    assign note_tick = en && (r_presc == '0);
    assign at_end    = w_note_last_cycle && (r_idx == last_idx);

endmodule
`default_nettype wire

// File: rtl/song_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : song_scheduler
// Purpose  : Arbitrates theme/eat/death songs and sequences the note index.
// Revision : 1.0
// ============================================================================
module song_scheduler
    import music_pkg::*;
#(
    parameter int TICKS_PER_NOTE = 6_250_000,
    parameter int TICK_W         = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       theme_req,
    input  logic [1:0] fx_req,
    output logic [1:0] fx_ack,
    output logic       fx_done,
    output logic [1:0] song_sel,
    output logic [5:0] note_idx,
    output logic       note_tick,
    output logic       playing
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_THEME = 2'd1;
    localparam logic [1:0] S_FX    = 2'd2;

    logic [1:0] r_state, w_state_nxt;
    song_e      r_song, w_song_nxt;
    song_e      w_cand;
    logic [1:0] r_pend, w_pend, w_clr;
    logic [1:0] r_ack, w_ack_nxt;
    logic       r_done, w_done_nxt;
    logic       w_load0;
    logic [5:0] w_last_idx;
    logic [5:0] w_cnt_idx;
    logic       w_cnt_tick;
    logic       w_at_end;

    note_index_counter #(
        .TICKS_PER_NOTE (TICKS_PER_NOTE),
        .TICK_W         (TICK_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load0     (w_load0),
        .last_idx  (w_last_idx),
        .note_idx  (w_cnt_idx),
        .note_tick (w_cnt_tick),
        .at_end    (w_at_end)
    );

    always_comb begin
        case (r_song)
            SONG_THEME: w_last_idx = 6'(THEME_LEN - 1);
            SONG_EAT:   w_last_idx = 6'(EAT_LEN - 1);
            SONG_DEATH: w_last_idx = 6'(DEATH_LEN - 1);
            default:    w_last_idx = 6'd0;
        endcase
    end

    // This cycle's pulses count as pending so acceptance lands next cycle.
    assign w_pend = r_pend | fx_req;
    assign w_cand = w_pend[1] ? SONG_DEATH : (w_pend[0] ? SONG_EAT : SONG_NONE);

    always_comb begin
        w_state_nxt = r_state;
        w_song_nxt  = r_song;
        w_clr       = 2'b00;
        w_ack_nxt   = 2'b00;
        w_done_nxt  = 1'b0;
        w_load0     = (r_state == S_IDLE);
        if (en) begin
            if ((r_state == S_FX) && w_at_end) begin
                // A finished effect no longer blocks lower-priority pending effects.
                w_done_nxt = 1'b1;
                w_load0    = 1'b1;
                if (w_cand != SONG_NONE) begin
                    w_state_nxt = S_FX;
                    w_song_nxt  = w_cand;
                    w_clr       = (w_cand == SONG_DEATH) ? 2'b10 : 2'b01;
                    w_ack_nxt   = w_clr;
                end else if (theme_req) begin
                    w_state_nxt = S_THEME;
                    w_song_nxt  = SONG_THEME;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_song_nxt  = SONG_NONE;
                end
            end else if ((w_cand != SONG_NONE) && (prio(w_cand) >= prio(r_song))) begin
                w_state_nxt = S_FX;
                w_song_nxt  = w_cand;
                w_load0     = 1'b1;
                w_clr       = (w_cand == SONG_DEATH) ? 2'b10 : 2'b01;
                w_ack_nxt   = w_clr;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (theme_req) begin
                            w_state_nxt = S_THEME;
                            w_song_nxt  = SONG_THEME;
                        end
                    end
                    S_THEME: begin
                        if (!theme_req) begin
                            w_state_nxt = S_IDLE;
                            w_song_nxt  = SONG_NONE;
                            w_load0     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_song  <= SONG_NONE;
            r_pend  <= 2'b00;
            r_ack   <= 2'b00;
            r_done  <= 1'b0;
        end else begin
            // Clearing after the OR keeps a same-cycle acked pulse from re-arming.
            r_pend  <= w_pend & ~w_clr;
            r_state <= w_state_nxt;
            r_song  <= w_song_nxt;
            r_ack   <= w_ack_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign song_sel  = r_song;
    assign note_idx  = w_cnt_idx;
    assign note_tick = w_cnt_tick && (r_state != S_IDLE);
    assign fx_ack    = r_ack & {2{en}};
    assign fx_done   = r_done & en;
    assign playing   = (r_song != SONG_NONE);

endmodule
`default_nettype wire

// File: tb/tb_song_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_song_scheduler
// Purpose  : Scoreboard bench for song_scheduler with TICKS_PER_NOTE = 4.
// Revision : 1.0
// ============================================================================
module tb_song_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       theme_req;
    logic [1:0] fx_req;
    logic [1:0] fx_ack;
    logic       fx_done;
    logic [1:0] song_sel;
    logic [5:0] note_idx;
    logic       note_tick;
    logic       playing;

    typedef struct packed {
        logic [1:0] ack;
        logic       done;
        logic [1:0] song;
        logic [5:0] idx;
        logic       tick;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_ev;
    ev_t exp_ev;
    int  n_checks = 0;
    int  n_fail   = 0;

    song_scheduler #(
        .TICKS_PER_NOTE (4),
        .TICK_W         (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .theme_req (theme_req),
        .fx_req    (fx_req),
        .fx_ack    (fx_ack),
        .fx_done   (fx_done),
        .song_sel  (song_sel),
        .note_idx  (note_idx),
        .note_tick (note_tick),
        .playing   (playing)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push(input logic [1:0] ack, input logic done, input logic [1:0] song);
        ev_t e;
        e.ack  = ack;
        e.done = done;
        e.song = song;
        e.idx  = 6'd0;
        e.tick = 1'b1;
        exp_q.push_back(e);
    endtask

    // Every ack/done pulse must match the next expected event, in order.
    always @(negedge clk) begin
        if ((fx_ack != 2'b00) || fx_done) begin
            got_ev = '{ack: fx_ack, done: fx_done, song: song_sel, idx: note_idx, tick: note_tick};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got ack=%b done=%b song=%0d idx=%0d tick=%b, none required at %0t",
                         got_ev.ack, got_ev.done, got_ev.song, got_ev.idx, got_ev.tick, $time);
            end else begin
                exp_ev = exp_q.pop_front();
                if (got_ev !== exp_ev) begin
                    n_fail++;
                    $display("FAIL event: got ack=%b done=%b song=%0d idx=%0d tick=%b, required ack=%b done=%b song=%0d idx=%0d tick=%b at %0t",
                             got_ev.ack, got_ev.done, got_ev.song, got_ev.idx, got_ev.tick,
                             exp_ev.ack, exp_ev.done, exp_ev.song, exp_ev.idx, exp_ev.tick, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b1; theme_req = 1'b0; fx_req = 2'b00;
        tick(3);
        sample();
        chk("rst_song", song_sel, 0);
        chk("rst_idx", note_idx, 0);
        chk("rst_tick", note_tick, 0);
        chk("rst_ack", fx_ack, 0);
        chk("rst_done", fx_done, 0);
        chk("rst_playing", playing, 0);

        // Theme start and full loop wrap
        rst = 1'b0;
        tick();
        theme_req = 1'b1;
        tick();
        sample();
        chk("theme_start_song", song_sel, 1);
        chk("theme_start_idx", note_idx, 0);
        chk("theme_start_tick", note_tick, 1);
        chk("theme_playing", playing, 1);
        tick(188);
        sample();
        chk("theme_last_idx", note_idx, 47);
        chk("theme_last_tick", note_tick, 1);
        tick(3);
        sample();
        chk("theme_last_mid_tick", note_tick, 0);
        tick();
        sample();
        chk("theme_wrap_idx", note_idx, 0);
        chk("theme_wrap_tick", note_tick, 1);

        // Eat preempts theme during note 10, theme resumes at 0
        tick(40);
        sample();
        chk("theme_note10", note_idx, 10);
        tick();
        fx_req = 2'b01;
        push(2'b01, 1'b0, 2'd2);
        push(2'b00, 1'b1, 2'd1);
        tick();
        fx_req = 2'b00;
        sample();
        chk("eat_song", song_sel, 2);
        tick(32);
        sample();
        chk("eat_end_song", song_sel, 1);
        chk("eat_end_idx", note_idx, 0);

        // Simultaneous requests: death first, then eat, then theme
        fx_req = 2'b11;
        push(2'b10, 1'b0, 2'd3);
        push(2'b01, 1'b1, 2'd2);
        push(2'b00, 1'b1, 2'd1);
        tick();
        fx_req = 2'b00;
        sample();
        chk("both_death_song", song_sel, 3);
        tick(64);
        sample();
        chk("both_eat_song", song_sel, 2);
        tick(32);
        sample();
        chk("both_theme_song", song_sel, 1);

        // Eat held during death; death restarts on a new death request
        fx_req = 2'b10;
        push(2'b10, 1'b0, 2'd3);
        tick();
        fx_req = 2'b00;
        tick(20);
        sample();
        chk("death_note5", note_idx, 5);
        fx_req = 2'b01;
        tick();
        fx_req = 2'b00;
        sample();
        chk("death_unaffected_song", song_sel, 3);
        chk("death_unaffected_idx", note_idx, 5);
        tick(7);
        sample();
        chk("death_note7", note_idx, 7);
        fx_req = 2'b10;
        push(2'b10, 1'b0, 2'd3);
        push(2'b01, 1'b1, 2'd2);
        push(2'b00, 1'b1, 2'd1);
        tick();
        fx_req = 2'b00;
        sample();
        chk("death_restart_idx", note_idx, 0);
        tick(64);
        sample();
        chk("held_eat_song", song_sel, 2);
        tick(32);
        sample();
        chk("after_eat_song", song_sel, 1);
        chk("after_eat_idx", note_idx, 0);

        // Freeze for 10 cycles in the middle of theme note 3
        tick(13);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("freeze_tick", note_tick, 0);
            chk("freeze_idx", note_idx, 3);
            tick();
        end
        en = 1'b1;
        tick(2);
        sample();
        chk("resume_idx", note_idx, 3);
        chk("resume_tick", note_tick, 0);
        tick();
        sample();
        chk("resume_next_idx", note_idx, 4);
        chk("resume_next_tick", note_tick, 1);

        // Request captured while frozen acks after enable returns
        en = 1'b0;
        tick();
        fx_req = 2'b01;
        push(2'b01, 1'b0, 2'd2);
        push(2'b00, 1'b1, 2'd1);
        tick();
        fx_req = 2'b00;
        tick();
        en = 1'b1;
        tick();
        sample();
        chk("frozen_req_song", song_sel, 2);
        tick(31);
        sample();
        chk("frozen_eat_last", song_sel, 2);
        tick();
        sample();
        chk("frozen_eat_back", song_sel, 1);

        // Theme request drop goes idle the next cycle
        theme_req = 1'b0;
        tick();
        sample();
        chk("idle_song", song_sel, 0);
        chk("idle_playing", playing, 0);
        chk("idle_tick", note_tick, 0);
        theme_req = 1'b1;
        tick();
        sample();
        chk("rethem_idx", note_idx, 0);
        chk("rethem_tick", note_tick, 1);

        // Reset during death note 9 with eat pending
        fx_req = 2'b10;
        push(2'b10, 1'b0, 2'd3);
        tick();
        fx_req = 2'b00;
        tick(36);
        sample();
        chk("death_note9", note_idx, 9);
        fx_req = 2'b01;
        tick();
        fx_req = 2'b00;
        rst = 1'b1;
        theme_req = 1'b0;
        tick();
        sample();
        chk("midrst_song", song_sel, 0);
        chk("midrst_idx", note_idx, 0);
        chk("midrst_tick", note_tick, 0);
        chk("midrst_ack", fx_ack, 0);
        chk("midrst_done", fx_done, 0);
        rst = 1'b0;
        tick(40);
        sample();
        chk("post_rst_song", song_sel, 0);
        chk("post_rst_playing", playing, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/song_scheduler.md
# song_scheduler

Sequences the per-song note index that feeds the note ROM and tone generator in the audio path, and arbitrates which song plays. Requesters are the looping background theme and two one-shot effects (eat-ghost, death). It generates the tempo tick, preempts by priority, resumes the theme after an effect completes, and reports acceptance and completion to the game FSM.

## Interface

Parameters:
- TICKS_PER_NOTE, 6_250_000: clk cycles per note (8 notes/s at 50 MHz); must be ≥ 2.
- TICK_W, 23: prescaler width; must satisfy 2^TICK_W ≥ TICKS_PER_NOTE.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable (game running); low freezes all state.
- theme_req  in  1  level; high = theme loop wanted.
- fx_req  in  2  one-cycle request pulses; bit0 eat, bit1 death.
- fx_ack  out  1x2  one-cycle pulse per bit when that effect starts.
- fx_done  out  1  one-cycle pulse when an effect plays its last note to completion.
- song_sel  out  2  0 none, 1 theme, 2 eat, 3 death.
- note_idx  out  6  current note index within song_sel.
- note_tick  out  1  one-cycle pulse on first cycle of every note.
- playing  out  1  song_sel != 0.

## Operation

- Song lengths: THEME 48, EAT 8, DEATH 16 notes; index runs 0..LEN-1.
- Pending: fx_req bits OR into pend[1:0] every cycle, including when en is low. A pend bit clears only on its ack or on rst.
- Priority: death > eat > theme. An effect starts when its pend bit is set and its priority ≥ the current song's. A same-song request restarts that song. Eat pending during death stays pending.
- Simultaneous pend = 11: death starts and acks; eat stays pending.
- FSM states: S_IDLE, S_THEME, S_FX, where S_FX's song is held in song_sel.
  - S_IDLE → S_FX on any pend; otherwise → S_THEME if theme_req.
  - S_THEME → S_FX on any pend. → S_IDLE on the cycle after theme_req is sampled low, which stops the theme immediately.
  - S_THEME at last note end: wraps to note 0 with note_tick.
  - S_FX at last note end: pulses fx_done, then goes to the next pending effect, else S_THEME if theme_req, else S_IDLE.
- Any song start or restart loads note_idx=0, clears the prescaler and asserts note_tick.
- S_IDLE: song_sel=0, note_idx=0, note_tick=0.
- en low: state, prescaler, note_idx and song_sel hold. note_tick, fx_ack and fx_done are forced 0.

## Timing

- Reset values: song_sel 0, note_idx 0, note_tick 0, fx_ack 00, fx_done 0, playing 0, pend 00, prescaler 0, state S_IDLE. Reset mid-song takes effect the next cycle and discards pending requests.
- Request latency: fx_req pulse in cycle N, accepted → in cycle N+1 fx_ack, new song_sel, note_idx=0 and note_tick are all 1/valid.
- theme_req rising in N → theme starts in N+1 when nothing is pending.
- Note duration is exactly TICKS_PER_NOTE enabled cycles, including the last note. note_tick recurs every TICKS_PER_NOTE enabled cycles.
- Effect end: fx_done coincides with the first cycle of the following song (its note_tick) or of S_IDLE.
- Preemption discards the interrupted song's index. A resumed theme always restarts at note 0.

## Structure

- Package music_pkg holds:
  - song_e enum (SONG_NONE, SONG_THEME, SONG_EAT, SONG_DEATH);
  - length constants THEME_LEN, EAT_LEN, DEATH_LEN;
  - a prio(song_e) function returning 0..3.
- Sub-module note_index_counter contains the prescaler and 6-bit index.
  - Inputs: en, load0, last_idx.
  - Outputs: note_idx, note_tick, at_end. at_end is high on the final prescaler cycle of note last_idx.
- The scheduler owns the FSM, pend register and output pulses.

## Test plan

All scenarios use TICKS_PER_NOTE=4.

- Reset, then theme_req=1: song_sel=1 next cycle. note_tick every 4 cycles; note_idx 0..47, then 0 again at cycle 193.
- Eat pulse during theme note 10: next cycle fx_ack=01, song_sel=2, note_idx=0. After 32 cycles fx_done=1 with song_sel=1, note_idx=0.
- fx_req=11 in one cycle: death acks and plays 64 cycles. Then eat acks with fx_done, plays 32 cycles, then theme.
- Death playing note 5, eat pulse: no ack, pend=01, death unaffected. Death pulse at note 7: restarts death at note_idx 0 with fx_ack=10.
- en low 10 cycles mid-note 3 of theme: outputs frozen, no note_tick. Remaining prescaler cycles resume; a fx_req pulse during the freeze acks on the first enabled cycle.
- rst asserted during death note 9 with eat pending: next cycle all outputs 0. The eat does not play afterwards.
